// File: rtl/snow64_instr_encoder.sv
// Snow64 instruction encoder: validates decoded fields, packs them into the
// 32-bit per-group word, and queues {word, err} in a DEPTH-entry FIFO.
module snow64_instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_group,
  input  logic        in_op_type,
  input  logic [3:0]  in_ra_index,
  input  logic [3:0]  in_rb_index,
  input  logic [3:0]  in_rc_index,
  input  logic [3:0]  in_oper,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [1:0]  out_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_GRP  = 2'd1,
    ERR_OPER = 2'd2,
    ERR_IMM  = 2'd3
  } err_e;

  typedef struct packed {
    logic [31:0] instr;
    err_e        err;
  } entry_t;

  entry_t          enc;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // Immediate fits signed N bits when everything from bit N-1 up is a copy
  // of the sign.
  logic imm_fit12, imm_fit16, imm_fit20;
  assign imm_fit12 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign imm_fit16 = (&in_imm[63:15]) | ~(|in_imm[63:15]);
  assign imm_fit20 = (&in_imm[63:19]) | ~(|in_imm[63:19]);

  always_comb begin
    enc = '{instr: 32'h0, err: ERR_OK};
    unique case (in_group)
      3'd0: begin
        if (in_oper >= 4'd13)   enc.err = ERR_OPER;
        else if (!imm_fit12)    enc.err = ERR_IMM;
        else enc.instr = {in_group, in_op_type, in_ra_index, in_rb_index,
                          in_rc_index, in_oper, in_imm[11:0]};
      end
      3'd1: begin
        if (in_oper >= 4'd12)   enc.err = ERR_OPER;
        else if (!imm_fit20)    enc.err = ERR_IMM;
        else enc.instr = {in_group, 1'b0, in_ra_index, in_oper, in_imm[19:0]};
      end
      3'd2, 3'd3: begin
        if (in_oper >= 4'd9)    enc.err = ERR_OPER;
        else if (!imm_fit12)    enc.err = ERR_IMM;
        else enc.instr = {in_group, 1'b0, in_ra_index, in_rb_index,
                          in_rc_index, in_oper, in_imm[11:0]};
      end
      3'd4: begin
        if (in_oper >= 4'd9)    enc.err = ERR_OPER;
        else if (!imm_fit16)    enc.err = ERR_IMM;
        else enc.instr = {in_group, in_op_type, in_ra_index, in_rb_index,
                          in_oper, in_imm[15:0]};
      end
      default: enc.err = ERR_GRP;
    endcase
  end

  // in_ready depends only on the registered count (and reset), never on
  // out_ready, so a pop while full frees the slot for the next cycle.
  assign in_ready  = !rst && (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr = out_valid ? mem_q[rd_q].instr : 32'h0;
  assign out_err   = out_valid ? mem_q[rd_q].err   : ERR_OK;

  always_comb begin
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= enc;
  end

endmodule
